// File: rtl/lsu_pkg.sv
// Shared op codes, FSM encoding and decode helpers for the load/store bus master.
package lsu_pkg;

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_t;

    function automatic logic is_store(input logic [2:0] op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] lane);
        case (op)
            OP_LW, OP_SW:         return lane != 2'b00;
            OP_LH, OP_LHU, OP_SH: return lane[0];
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_fmt.sv
// Byte-lane formatter: store enables/replication and load extraction/extension.
module lsu_lane_fmt
    import lsu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] bus_wdata,
    output logic [31:0] load_data
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    always_comb begin
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
        case (lane)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase

        be        = 4'b1111;
        bus_wdata = wdata;
        load_data = rdata;
        case (op)
            OP_LH: begin
                be        = lane[1] ? 4'b1100 : 4'b0011;
                load_data = {{16{half_sel[15]}}, half_sel};
            end
            OP_LHU: begin
                be        = lane[1] ? 4'b1100 : 4'b0011;
                load_data = {16'h0000, half_sel};
            end
            OP_SH: begin
                be        = lane[1] ? 4'b1100 : 4'b0011;
                bus_wdata = {2{wdata[15:0]}};
            end
            OP_LB: begin
                be        = 4'b0001 << lane;
                load_data = {{24{byte_sel[7]}}, byte_sel};
            end
            OP_LBU: begin
                be        = 4'b0001 << lane;
                load_data = {24'h000000, byte_sel};
            end
            OP_SB: begin
                be        = 4'b0001 << lane;
                bus_wdata = {4{wdata[7:0]}};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_bus_master.sv
// MEM-stage load/store initiator: alignment check, req/gnt/rvalid bus sequencing, load return.
module lsu_bus_master
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_valid,
    input  logic [2:0]        cpu_op,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [31:0]       cpu_pc,
    output logic              stall,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              exc_adel,
    output logic              exc_ades,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [31:0]       bus_rdata
);

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [1:0]        lane_q, lane_d;
    logic              req_q, req_d, we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d;
    logic              done_q, done_d, adel_q, adel_d, ades_q, ades_d;

    logic [2:0]  fmt_op;
    logic [1:0]  fmt_lane;
    logic [3:0]  fmt_be;
    logic [31:0] fmt_wdata, fmt_load;

    // Formatter sees the incoming op while idle and the latched op afterwards.
    assign fmt_op   = (state_q == StIdle) ? cpu_op : op_q;
    assign fmt_lane = (state_q == StIdle) ? cpu_addr[1:0] : lane_q;

    lsu_lane_fmt u_lane_fmt (
        .op        (fmt_op),
        .lane      (fmt_lane),
        .wdata     (cpu_wdata),
        .rdata     (bus_rdata),
        .be        (fmt_be),
        .bus_wdata (fmt_wdata),
        .load_data (fmt_load)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        lane_d  = lane_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        adel_d  = 1'b0;
        ades_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cpu_valid) begin
                    if (is_misaligned(cpu_op, cpu_addr[1:0])) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        adel_d  = !is_store(cpu_op);
                        ades_d  = is_store(cpu_op);
                    end else begin
                        state_d = StReq;
                        op_d    = cpu_op;
                        lane_d  = cpu_addr[1:0];
                        req_d   = 1'b1;
                        we_d    = is_store(cpu_op);
                        addr_d  = {cpu_addr[ADDR_W-1:2], 2'b00};
                        be_d    = fmt_be;
                        wdata_d = fmt_wdata;
                    end
                end
            end
            StReq: begin
                if (bus_gnt) begin
                    req_d = 1'b0;
                    if (is_store(op_q)) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (bus_rvalid) begin
                    rdata_d = fmt_load;
                    done_d  = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            op_q    <= 3'd0;
            lane_q  <= 2'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            done_q  <= 1'b0;
            adel_q  <= 1'b0;
            ades_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            lane_q  <= lane_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            adel_q  <= adel_d;
            ades_q  <= ades_d;
        end
    end

    assign stall     = cpu_valid && (state_q != StDone);
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign exc_adel  = adel_q;
    assign exc_ades  = ades_q;
    assign bus_req   = req_q;
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_be    = be_q;
    assign bus_wdata = wdata_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (reset && state_q == StReq && bus_gnt && we_q) begin
            $display("@%h: *%h <= %h", cpu_pc, addr_q, wdata_q);
        end
    end
`endif

endmodule

// File: tb/tb_lsu_bus_master.sv
// Directed bench for lsu_bus_master with a scoreboard of expected op outcomes.
module tb_lsu_bus_master;

    localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3, LBU = 3'd4;
    localparam logic [2:0] SW = 3'd5, SH = 3'd6, SB = 3'd7;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_valid = 1'b0;
    logic [2:0]  cpu_op = 3'd0;
    logic [31:0] cpu_addr = 32'd0, cpu_wdata = 32'd0, cpu_pc = 32'd0;
    logic        stall, done, exc_adel, exc_ades, bus_req, bus_we;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_gnt = 1'b0, bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = 32'd0;

    always #5 clk = ~clk;

    lsu_bus_master #(.ADDR_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_valid  (cpu_valid),
        .cpu_op     (cpu_op),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_pc     (cpu_pc),
        .stall      (stall),
        .done       (done),
        .rdata      (rdata),
        .exc_adel   (exc_adel),
        .exc_ades   (exc_ades),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_gnt    (bus_gnt),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        adel;
        logic        ades;
        int          lat;
        logic        bus;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rdata = 32'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [31:0] addr,
                                   input logic [31:0] wd, input logic [31:0] word,
                                   input int gd, input int rd);
        exp_t        e;
        logic [1:0]  ln;
        logic [31:0] sh;
        logic        mis, st;
        ln  = addr[1:0];
        st  = (op >= SW);
        mis = ((op == LW || op == SW) && ln != 2'd0) ||
              ((op == LH || op == LHU || op == SH) && ln[0]);
        sh  = word >> (8 * ln);
        e.adel  = mis && !st;
        e.ades  = mis && st;
        e.bus   = !mis;
        e.we    = st;
        e.addr  = addr & 32'hFFFF_FFFC;
        e.lat   = mis ? 1 : (st ? 2 + gd : 3 + gd + rd);
        e.rdata = last_rdata;
        e.wdata = wd;
        e.be    = 4'hF;
        if (op == LH || op == LHU || op == SH) e.be = ln[1] ? 4'hC : 4'h3;
        if (op == LB || op == LBU || op == SB) e.be = 4'h1 << ln;
        if (op == SH) e.wdata = {wd[15:0], wd[15:0]};
        if (op == SB) e.wdata = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
        if (!mis && !st) begin
            case (op)
                LW:      e.rdata = word;
                LH:      e.rdata = {{16{sh[15]}}, sh[15:0]};
                LHU:     e.rdata = {16'h0, sh[15:0]};
                LB:      e.rdata = {{24{sh[7]}}, sh[7:0]};
                default: e.rdata = {24'h0, sh[7:0]};
            endcase
        end
        return e;
    endfunction

    // Drives one op and plays the responder: gnt after gd waiting cycles, rvalid rd cycles later.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] word, input int gd,
                         input int rd);
        exp_t e, x;
        int   c, gcnt, rcnt;
        bit   granted, fin;
        e = model(op, addr, wd, word, gd, rd);
        exp_q.push_back(e);
        if (e.bus && !e.we) last_rdata = e.rdata;
        cpu_op = op; cpu_addr = addr; cpu_wdata = wd; cpu_pc = 32'h0040_0000 + addr;
        cpu_valid = 1'b1;
        c = 0; gcnt = 0; rcnt = 0; granted = 0; fin = 0;
        while (!fin) begin
            @(posedge clk); #1;
            c++;
            bus_gnt = 1'b0;
            bus_rvalid = 1'b0;
            if (done) begin
                x = exp_q.pop_front();
                check({tag, " latency"}, c, x.lat);
                check({tag, " rdata"}, rdata, x.rdata);
                check({tag, " exc_adel"}, exc_adel, x.adel);
                check({tag, " exc_ades"}, exc_ades, x.ades);
                check({tag, " stall@done"}, stall, 1'b0);
                check({tag, " bus_req@done"}, bus_req, 1'b0);
                cpu_valid = 1'b0;
                fin = 1;
            end else if (c > 60) begin
                check({tag, " timeout done"}, done, 1'b1);
                void'(exp_q.pop_front());
                cpu_valid = 1'b0;
                fin = 1;
            end else begin
                check({tag, " stall"}, stall, 1'b1);
                if (!e.bus) begin
                    check({tag, " no bus_req"}, bus_req, 1'b0);
                end else if (!granted) begin
                    check({tag, " bus_req"}, bus_req, 1'b1);
                    check({tag, " bus_we"}, bus_we, e.we);
                    check({tag, " bus_addr"}, bus_addr, e.addr);
                    check({tag, " bus_be"}, bus_be, e.be);
                    check({tag, " bus_wdata"}, bus_wdata, e.wdata);
                    if (gcnt == gd) begin
                        bus_gnt = 1'b1;
                        granted = 1;
                    end else begin
                        gcnt++;
                        bus_rvalid = 1'b1;  // must be ignored before the grant
                        bus_rdata = 32'hBAD0_BAD0;
                    end
                end else begin
                    check({tag, " bus_req after gnt"}, bus_req, 1'b0);
                    if (rcnt == rd) begin
                        bus_rvalid = 1'b1;
                        bus_rdata = word;
                    end else begin
                        rcnt++;
                    end
                end
            end
        end
        @(posedge clk); #1;
        check({tag, " done one cycle"}, done, 1'b0);
        check({tag, " exc clear"}, {exc_adel, exc_ades}, 2'b00);
    endtask

    task automatic reset_abort(input string tag, input bit in_wait);
        cpu_op = LW; cpu_addr = 32'h40; cpu_valid = 1'b1;
        @(posedge clk); #1;
        check({tag, " req before reset"}, bus_req, 1'b1);
        if (in_wait) begin
            bus_gnt = 1'b1;
            @(posedge clk); #1;
            bus_gnt = 1'b0;
        end
        reset = 1'b0;
        cpu_valid = 1'b0;
        #1;
        check({tag, " bus_req in reset"}, bus_req, 1'b0);
        check({tag, " done in reset"}, done, 1'b0);
        check({tag, " rdata in reset"}, rdata, 32'd0);
        last_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check({tag, " no done after abort"}, done, 1'b0);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset bus_req", bus_req, 1'b0);
        check("reset bus_we", bus_we, 1'b0);
        check("reset bus_be", bus_be, 4'd0);
        check("reset bus_addr", bus_addr, 32'd0);
        check("reset bus_wdata", bus_wdata, 32'd0);
        check("reset rdata", rdata, 32'd0);
        check("reset done", done, 1'b0);
        check("reset exc", {exc_adel, exc_ades}, 2'b00);
        check("reset stall", stall, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;

        do_op("sw held gnt", SW,  32'h10, 32'hDEAD_BEEF, 32'h0, 3, 0);
        do_op("sb lane3",    SB,  32'h13, 32'h0000_00A5, 32'h0, 0, 0);
        do_op("lb lane1",    LB,  32'h11, 32'h0,         32'h1234_80FF, 0, 0);
        do_op("lbu lane1",   LBU, 32'h11, 32'h0,         32'h1234_80FF, 0, 0);
        do_op("lh lane2",    LH,  32'h22, 32'h0,         32'h8001_7FFF, 1, 2);
        do_op("lhu lane2",   LHU, 32'h22, 32'h0,         32'h8001_7FFF, 0, 1);
        do_op("lw misalign", LW,  32'h06, 32'h0,         32'h0, 0, 0);
        do_op("sh misalign", SH,  32'h01, 32'h1234_5678, 32'h0, 0, 0);
        do_op("sh lane2",    SH,  32'h22, 32'h0000_BEEF, 32'h0, 1, 0);
        do_op("lb lane0",    LB,  32'h30, 32'h0,         32'hAABB_CC7F, 0, 0);
        do_op("lw word",     LW,  32'h0C, 32'h0,         32'hCAFE_F00D, 2, 1);

        reset_abort("rst in req", 1'b0);
        reset_abort("rst in wait", 1'b1);
        do_op("lw after rst", LW, 32'h44, 32'h0, 32'h0BAD_F00D, 0, 0);

        check("scoreboard empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_bus_master.md
Name: lsu_bus_master

Overview:
- Load/store initiator in the CPU MEM stage; the requesting side of the data-memory interface.
- Takes one CPU memory op at a time (lw/lh/lhu/lb/lbu/sw/sh/sb).
- Checks alignment, then issues a word-aligned, byte-enabled request to a variable-latency memory responder over a req/gnt/rvalid handshake.
- Stalls the pipeline until the op completes, and returns sign- or zero-extended load data or an address-error flag.

Parameters:
ADDR_W, 32, byte-address width on both CPU and bus sides.

Ports:
clk  input  1  clock; all state on rising edge.
reset  input  1  asynchronous, active-low reset (asserted when 0).
cpu_valid  input  1  memory op present; held stable by the CPU until done.
cpu_op  input  3  0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, 5 SW, 6 SH, 7 SB.
cpu_addr  input  ADDR_W  byte address.
cpu_wdata  input  32  store data, right-aligned.
cpu_pc  input  32  PC of the op, used for the store trace.
stall  output  1  cpu_valid && state!=DONE.
done  output  1  one-cycle completion pulse.
rdata  output  32  extended load result; holds its value until the next load completes.
exc_adel  output  1  misaligned load; valid only with done.
exc_ades  output  1  misaligned store; valid only with done.
bus_req  output  1  request valid.
bus_we  output  1  1 = write.
bus_addr  output  ADDR_W  {cpu_addr[ADDR_W-1:2],2'b00}.
bus_be  output  4  byte enables.
bus_wdata  output  32  lane-replicated store data.
bus_gnt  input  1  responder accepts the request this cycle.
bus_rvalid  input  1  read data valid.
bus_rdata  input  32  read word.

Behaviour:
- Reset (reset==0, async):
  - state IDLE.
  - bus_req, bus_we, bus_be, bus_addr, bus_wdata, rdata, done, exc_adel, exc_ades all 0.
  - Reset mid-transaction abandons the op: bus_req falls immediately and no done is produced.
- States are IDLE, REQ, WAIT, DONE. All outputs are registered except stall.
- IDLE:
  - If cpu_valid is 0, stay in IDLE.
  - Misaligned op goes directly to DONE with exc_adel (loads) or exc_ades (stores) set. No bus activity. Misaligned means:
    - LW/SW with addr[1:0]!=0.
    - LH/LHU/SH with addr[0]!=0.
  - Aligned op: register op, lane, bus_addr, bus_be and bus_wdata; set bus_req=1, set bus_we for stores; go to REQ.
- REQ:
  - bus_req stays 1 and all bus_* outputs stay stable until bus_gnt. The request is never retracted.
  - On gnt with a store: drop bus_req and go to DONE.
  - On gnt with a load: drop bus_req and go to WAIT.
  - bus_rvalid is ignored in REQ.
- WAIT: on bus_rvalid, latch the extracted and extended value into rdata and go to DONE. There is no timeout.
- DONE:
  - done=1 for exactly one cycle, then IDLE unconditionally. Exception flags clear on exit.
  - The op held in DONE is not re-accepted; the next cycle's cpu_valid is a new op.
- Byte lanes (lane = addr[1:0]):
  - SB: be = 4'b0001<<lane; wdata = byte replicated ×4.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011; wdata = half replicated ×2.
  - SW: be = 4'b1111; wdata as given.
  - Loads drive the same enables pattern for their width; be is informational only for loads.
- Load extraction: pick the byte or half from lane. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Minimum latency (cycles from acceptance in IDLE):
  - store: done at +2 with immediate gnt.
  - load: done at +3 with immediate gnt and next-cycle rvalid.
  - misaligned: done at +1.
- Store trace: at the gnt cycle of a store, $display("@%h: *%h <= %h", pc, bus_addr, bus_wdata).

Decomposition:
- Package lsu_pkg holds:
  - op code localparams (OP_LW..OP_SB).
  - state encoding.
  - is_store / is_misaligned helper functions.
- One combinational sub-module, lsu_lane_fmt:
  - (op, lane, wdata) -> (be, bus_wdata) for stores.
  - (op, lane, rdata) -> extended result for loads.

Test Plan:
- SW addr 0x0000_0010, data 0xDEADBEEF, gnt held 0 for 3 cycles -> bus_req/addr/be=1111/wdata stable throughout; done exactly 1 cycle after gnt; stall 0 in DONE.
- SB addr 0x13, data 0x000000A5 -> bus_addr 0x10, be 1000, bus_wdata 0xA5A5A5A5.
- LB then LBU at addr 0x11, bus_rdata 0x1234_80FF -> rdata 0xFFFFFF80 then 0x00000080.
- LH addr 0x22, bus_rdata 0x8001_7FFF -> rdata 0xFFFF8001; LHU same -> 0x00008001.
- LW addr 0x06 -> no bus_req; done + exc_adel at +1, rdata unchanged. SH addr 0x01 -> exc_ades, no bus activity.
- reset driven 0 during WAIT of an LW -> bus_req 0 immediately, no done; after release a new LW completes normally.
